// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the router output path.
//   PKT_W    - packet width shared by arbiter, output FIFO and link
//   CREDITS  - default downstream input-buffer depth
//   CREDIT_W - default credit counter width (2**CREDIT_W > CREDITS)
//   link_state_e - link controller FSM encoding
package noc_pkg;
  localparam int PKT_W    = 64;
  localparam int CREDITS  = 4;
  localparam int CREDIT_W = 3;

  typedef enum logic [1:0] {
    LINK_INIT   = 2'd0,
    LINK_ACTIVE = 2'd1,
    LINK_ERROR  = 2'd2
  } link_state_e;
endpackage

// File: rtl/credit_counter.sv
// credit_counter: downstream credit tracker for the link transmitter.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   load_i      - load the full credit allotment (link init)
//   inc_i       - one credit returned by downstream
//   dec_i       - one credit consumed by a FIFO read
//   count_o     - credits currently available
//   overflow_o  - a return arrived with the count already full (this cycle)
module credit_counter #(
  parameter int CREDITS  = 4,
  parameter int CREDIT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CREDIT_W-1:0] count_o,
  output logic                overflow_o
);
  localparam logic [CREDIT_W-1:0] MAX_CNT = CREDIT_W'(CREDITS);

  logic [CREDIT_W-1:0] count_q, count_d;

  // Simultaneous inc and dec cancel; an increment at full count saturates
  // and is reported as an overflow.
  always_comb begin
    count_d    = count_q;
    overflow_o = 1'b0;
    if (load_i) begin
      count_d = MAX_CNT;
    end else if (inc_i && !dec_i) begin
      if (count_q == MAX_CNT) overflow_o = 1'b1;
      else                    count_d    = count_q + CREDIT_W'(1);
    end else if (dec_i && !inc_i) begin
      count_d = count_q - CREDIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/link_tx_ctrl.sv
// link_tx_ctrl: credit-based transmit controller for one router output port.
// Pops the output FIFO only while downstream has a free slot and forwards
// each packet onto the link two cycles after the pop.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   fifo_empty/fifo_dout - output FIFO status and read data (data valid the
//                          cycle after rd_en)
//   rd_en               - FIFO pop (combinational)
//   link_ready          - downstream initialised, sampled only in INIT
//   credit_return       - one pulse per freed downstream slot
//   link_valid/link_packet - registered link outputs
//   credit_count        - credits available
//   link_state          - FSM state (0 INIT, 1 ACTIVE, 2 ERROR)
//   credit_err          - sticky credit overflow flag
//   sent_count/stall_count - statistics, built only with LINK_TX_STATS_EN,
//                          otherwise tied to 0
// Handshake: a FIFO entry is consumed in every cycle where rd_en=1 at the
// rising edge; fifo_dout carries that entry for the following cycle, and
// link_valid=1 marks a cycle where link_packet holds a new packet (no
// backpressure from the link; flow control is purely by credits).
module link_tx_ctrl
  import noc_pkg::*;
#(
  parameter int PKT_W    = noc_pkg::PKT_W,
  parameter int CREDITS  = noc_pkg::CREDITS,
  parameter int CREDIT_W = noc_pkg::CREDIT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fifo_empty,
  input  logic [PKT_W-1:0]    fifo_dout,
  output logic                rd_en,
  input  logic                link_ready,
  input  logic                credit_return,
  output logic                link_valid,
  output logic [PKT_W-1:0]    link_packet,
  output logic [CREDIT_W-1:0] credit_count,
  output logic [1:0]          link_state,
  output logic                credit_err,
  output logic [15:0]         sent_count,
  output logic [15:0]         stall_count
);
  link_state_e         state_q;
  logic                rd_pending_q;
  logic                link_valid_q;
  logic [PKT_W-1:0]    link_packet_q;
  logic                credit_err_q;
  logic [CREDIT_W-1:0] cnt;
  logic                cnt_load, cnt_inc, cnt_overflow;

  assign rd_en    = (state_q == LINK_ACTIVE) && !fifo_empty && (cnt != '0);
  assign cnt_load = (state_q == LINK_INIT) && link_ready;
  // Returns are only meaningful once credits have been loaded; in ERROR the
  // count is frozen.
  assign cnt_inc  = (state_q == LINK_ACTIVE) && credit_return;

  credit_counter #(
    .CREDITS  (CREDITS),
    .CREDIT_W (CREDIT_W)
  ) u_credit_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .inc_i      (cnt_inc),
    .dec_i      (rd_en),
    .count_o    (cnt),
    .overflow_o (cnt_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LINK_INIT;
      rd_pending_q  <= 1'b0;
      link_valid_q  <= 1'b0;
      link_packet_q <= '0;
      credit_err_q  <= 1'b0;
    end else begin
      // A read issued last cycle always completes, even after entering ERROR.
      rd_pending_q <= rd_en;
      link_valid_q <= rd_pending_q;
      if (rd_pending_q) link_packet_q <= fifo_dout;

      case (state_q)
        LINK_INIT: begin
          if (link_ready) state_q <= LINK_ACTIVE;
        end
        LINK_ACTIVE: begin
          if (cnt_overflow) begin
            state_q      <= LINK_ERROR;
            credit_err_q <= 1'b1;
          end
        end
        default: ; // ERROR is left only through reset
      endcase
    end
  end

  assign link_valid   = link_valid_q;
  assign link_packet  = link_packet_q;
  assign credit_count = cnt;
  assign link_state   = state_q;
  assign credit_err   = credit_err_q;

`ifdef LINK_TX_STATS_EN
  logic [15:0] sent_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      if (link_valid_q) sent_q <= sent_q + 16'd1;
      if ((state_q == LINK_ACTIVE) && !fifo_empty && (cnt == '0))
        stall_q <= stall_q + 16'd1;
    end
  end

  assign sent_count  = sent_q;
  assign stall_count = stall_q;
`else
  assign sent_count  = '0;
  assign stall_count = '0;
`endif
endmodule

// File: doc/link_tx_ctrl.md
# link_tx_ctrl

Credit-based transmit controller for one router output port. Drains the output FIFO written by the 4-input round-robin arbiter and drives packets onto the inter-router link. Issues a FIFO read only when the downstream router has a free buffer slot, so no packet is ever dropped. Runs a small link FSM: init handshake, active transfer, sticky error on credit protocol violation.

## Interface
- `PKT_W`, 64, packet width; matches arbiter/FIFO packet width
- `CREDITS`, 4, downstream input-buffer depth; credit count loaded at link init
- `CREDIT_W`, 3, credit counter width; must satisfy 2^CREDIT_W > CREDITS
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `fifo_empty` in 1: output FIFO empty
- `fifo_dout` in PKT_W: FIFO read data, valid the cycle after `rd_en`
- `rd_en` out 1: FIFO pop request (Mealy, combinational)
- `link_ready` in 1: downstream buffers initialised (level)
- `credit_return` in 1: one-cycle pulse per freed downstream slot
- `link_valid` out 1: `link_packet` valid this cycle (registered)
- `link_packet` out PKT_W: packet to downstream (registered)
- `credit_count` out CREDIT_W: credits currently available
- `link_state` out 2: 0=INIT, 1=ACTIVE, 2=ERROR
- `credit_err` out 1: sticky credit overflow flag
- `sent_count` out 16: packets sent (stats build only)
- `stall_count` out 16: cycles stalled on zero credits (stats build only)

## Operation
- FSM INIT: `credit_count`=0, `rd_en`=0. When `link_ready`=1, load `credit_count`=CREDITS and move to ACTIVE next cycle.
- FSM ACTIVE: `rd_en` = !`fifo_empty` && `credit_count`>0. Each `rd_en` reserves one credit (decrement at that edge).
- `rd_pending` register <= `rd_en`. When `rd_pending`=1: `link_packet` <= `fifo_dout`, `link_valid` <= 1. Otherwise `link_valid` <= 0; `link_packet` holds its value.
- `credit_return` increments `credit_count`. If `rd_en` and `credit_return` occur in the same cycle, the count is unchanged.
- Credit return that would exceed CREDITS: `credit_err` <= 1, count saturates at CREDITS, FSM goes to ERROR.
- `credit_return` in INIT is ignored.
- ERROR: `rd_en`=0. An in-flight `rd_pending` packet still completes. Only `reset` exits ERROR.
- `link_ready` dropping in ACTIVE has no effect. It is sampled only in INIT.

## Timing
- Reset values: `rd_en`=0, `link_valid`=0, `link_packet`=0, `credit_count`=0, `link_state`=INIT, `credit_err`=0, stats counters=0, `rd_pending`=0.
- Latency: `rd_en` in cycle N → `link_valid` high in cycle N+2.
- Throughput: one packet per cycle while credits remain and the FIFO is non-empty.
- First possible `rd_en` is the cycle after `link_ready` is sampled in INIT.
- With credits=1 and simultaneous `rd_en` and `credit_return`: count stays 1 and back-to-back reads continue.
- Reset mid-transfer: the in-flight read is discarded, `link_valid`=0 from the next cycle, credits are cleared and the FSM returns to INIT. The FIFO is reset by its own logic.

## Configuration
- `LINK_TX_STATS_EN` defined:
  - `sent_count` increments on each `link_valid` cycle.
  - `stall_count` increments each ACTIVE cycle with !`fifo_empty` && `credit_count`=0.
  - Both counters are 16-bit and wrap modulo 2^16.
- `LINK_TX_STATS_EN` undefined: both ports are present but tied to 0, and no counter logic is built.

## Structure
- Shared package `noc_pkg` holds:
  - `PKT_W`
  - link-state enum: INIT=2'd0, ACTIVE=2'd1, ERROR=2'd2
  - default `CREDITS` and `CREDIT_W`
- Sub-module `credit_counter` holds:
  - inputs: load, inc, dec
  - saturation and overflow detection
  - count output

## Test plan
- Reset, `link_ready`=1 at cycle 3 → ACTIVE at cycle 4, `credit_count`=4, `link_valid`=0 throughout.
- FIFO holds 0xA1, 0xA2, 0xA3 with 4 credits → `rd_en` high 3 consecutive cycles; `link_packet` shows 0xA1/0xA2/0xA3 on 3 consecutive cycles starting 2 cycles after the first `rd_en`; `credit_count`=1.
- FIFO holds 6 packets, no credit returns → exactly 4 sent, `rd_en` low with `credit_count`=0. One `credit_return` pulse → exactly one more `rd_en`. Stats build: `stall_count` increments during the stall.
- `credit_count`=1 with `rd_en` and `credit_return` in the same cycle → count stays 1 and sending continues uninterrupted.
- `credit_return` with `credit_count`=4 → `credit_err`=1, `link_state`=ERROR, no further `rd_en` until reset.
- `reset` asserted the cycle after an `rd_en` → no `link_valid` pulse, `credit_count`=0, `link_state`=INIT next cycle.
